fwd_interlock_unit: RTL and testbench
=====================================

// Module: fwd_interlock_unit
// PURPOSE
//  Parametrised forwarding + load-use interlock for the in-order MIPS pipeline.
//  Tracks every in-flight destination in an NSTAGES-deep tag pipeline behind the
//  issue (ID) stage and forwards the youngest in-flight producer's result to each
//  of NSRC source operands. If that producer's data is not yet available, the
//  unit stalls issue and inserts a bubble. Replaces fixed 2-stage/2-operand
//  forwarding and adds a saturating stall-cycle counter.
// PARAMETERS
//  DW       32  data width
//  AW        5  register address width; address 0 is never forwarded or tracked
//  NSTAGES   3  tracked stages after ID (0=EX, 1=MEM, 2=WB); range 1..8
//  NSRC      2  source operands checked per issued instruction
//  CW       16  stall counter width
//  SW          localparam = max(1,$clog2(NSTAGES))
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous active-low reset
//  issue_valid_i  in   1         instruction present in ID
//  issue_we_i     in   1         ID instruction writes a register
//  issue_rd_i     in   AW        ID destination register
//  issue_rdy_i    in   SW        first stage index at which the result is valid (ALU=0, load=1)
//  src_used_i     in   NSRC      per-operand: ID instruction reads this operand
//  src_addr_i     in   NSRC*AW   operand register addresses, operand j at [j*AW +: AW]
//  rf_data_i      in   NSRC*DW   register-file read data
//  stage_data_i   in   NSTAGES*DW  result bus of stage s at [s*DW +: DW]
//  flush_i        in   1         squash ID instruction (branch/jump redirect)
//  src_data_o     out  NSRC*DW   resolved operand data
//  fwd_hit_o      out  NSRC      operand j taken from a stage bus
//  stall_o        out  1         hold PC and IF/ID; bubble enters stage 0
//  stall_cnt_o    out  CW        count of cycles with stall_o high, saturating
// BEHAVIOUR
//  Entry storage: per stage, v, rd[AW], rdy[SW]. issue_rdy_i > NSTAGES-1 is
//   clamped to NSTAGES-1.
//  Each cycle, every entry shifts s -> s+1. Stage NSTAGES-1 retires; its write is
//   visible in rf_data_i from the next cycle.
//  Stage 0 load:
//   - accept = issue_valid_i & issue_we_i & (issue_rd_i!=0) & ~stall_o & ~flush_i
//   - on accept: stage0 <= {1, issue_rd_i, rdy}; otherwise stage0.v <= 0 (bubble)
//  Match, operand j: entry s with v & rd==src_addr_j & src_addr_j!=0.
//   - lowest s (youngest) wins; older matches are ignored.
//  Resolution, operand j (combinational, 0-cycle latency):
//   - no match: src_data = rf_data_j, hit = 0
//   - youngest match at s with s >= rdy: src_data = stage_data[s], hit = 1
//   - youngest match with s < rdy: operand not ready. src_data = stage_data[s],
//     hit = 1 (don't-care while stalled).
//  stall_o = issue_valid_i & ~flush_i & OR_j(src_used_j & not_ready_j).
//   - flush dominates stall; the stall does not block the older stages.
//  A stalled instruction re-evaluates every cycle. Load-use with rdy=1 therefore
//   stalls exactly 1 cycle; rdy=r stalls r cycles for a back-to-back consumer.
//  stall_cnt_o increments on every clk edge where stall_o=1 and holds at 2^CW-1.
//  Reset (async, rst_n=0): all v=0, stall_cnt_o=0.
//   - outputs during and after reset: src_data_o=rf_data_i, fwd_hit_o=0,
//     stall_o=0.
//   - reset mid-stall drops all in-flight tags immediately.
//  Same register written by several in-flight entries: the youngest always wins,
//   even if it is not ready. The unit never falls back to an older ready value.
// TESTING
//  ALU chain: issue rd=5 rdy=0, then src0=5 next cycle, stage_data[0]=0xA5
//   -> src_data0=0xA5, hit0=1, stall_o=0.
//  Load-use: issue rd=8 rdy=1, next instr src1=8 -> stall_o=1 for 1 cycle, cnt=1;
//   following cycle src_data1=stage_data[1], stall_o=0.
//  Priority: rd=3 in stage2 (0x11) and stage0 (0x22), both ready
//   -> src_data=0x22. Youngest not ready -> stall, no fallback to 0x11.
//  Register 0 / unused / retire: src=0 or src_used=0 with a matching tag -> no
//   hit, no stall. A tag past stage NSTAGES-1 -> rf_data_i passed through.
//  Flush + reset: flush_i with stall condition -> stall_o=0, stage0 bubble.
//   rst_n low mid-stall -> stall_o=0 and cnt=0 asynchronously.
//   Force stall for 2^CW+3 cycles -> cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fwd_interlock_unit.sv
// Forwarding and load-use interlock for the in-order pipeline: tracks in-flight
// destinations behind ID, forwards the youngest producer and stalls on not-ready data.
module fwd_interlock_unit #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int CW      = 16,
  localparam int SW     = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid_i,
  input  logic                  issue_we_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic [SW-1:0]         issue_rdy_i,
  input  logic [NSRC-1:0]       src_used_i,
  input  logic [NSRC*AW-1:0]    src_addr_i,
  input  logic [NSRC*DW-1:0]    rf_data_i,
  input  logic [NSTAGES*DW-1:0] stage_data_i,
  input  logic                  flush_i,
  output logic [NSRC*DW-1:0]    src_data_o,
  output logic [NSRC-1:0]       fwd_hit_o,
  output logic                  stall_o,
  output logic [CW-1:0]         stall_cnt_o
);

  logic [NSTAGES-1:0] v_q, v_d;
  logic [AW-1:0]      rd_q  [NSTAGES];
  logic [AW-1:0]      rd_d  [NSTAGES];
  logic [SW-1:0]      rdy_q [NSTAGES];
  logic [SW-1:0]      rdy_d [NSTAGES];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NSRC-1:0]    not_ready;
  logic [SW-1:0]      rdy_clamp;
  logic               accept;

  assign rdy_clamp = (issue_rdy_i > SW'(NSTAGES - 1)) ? SW'(NSTAGES - 1) : issue_rdy_i;

  // Scan oldest to youngest so the youngest matching stage is the last one written.
  always_comb begin
    src_data_o = rf_data_i;
    fwd_hit_o  = '0;
    not_ready  = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int s = NSTAGES - 1; s >= 0; s--) begin
        if (src_used_i[j] && v_q[s] && (src_addr_i[j*AW +: AW] != '0) &&
            (rd_q[s] == src_addr_i[j*AW +: AW])) begin
          src_data_o[j*DW +: DW] = stage_data_i[s*DW +: DW];
          fwd_hit_o[j]           = 1'b1;
          not_ready[j]           = (SW'(s) < rdy_q[s]);
        end
      end
    end
  end

  assign stall_o = issue_valid_i & ~flush_i & (|(src_used_i & not_ready));
  assign accept  = issue_valid_i & issue_we_i & (issue_rd_i != '0) & ~stall_o & ~flush_i;

  always_comb begin
    v_d      = '0;
    v_d[0]   = accept;
    rd_d[0]  = issue_rd_i;
    rdy_d[0] = rdy_clamp;
    for (int s = 1; s < NSTAGES; s++) begin
      v_d[s]   = v_q[s-1];
      rd_d[s]  = rd_q[s-1];
      rdy_d[s] = rdy_q[s-1];
    end
    cnt_d = (stall_o && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int s = 0; s < NSTAGES; s++) begin
        rd_q[s]  <= '0;
        rdy_q[s] <= '0;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int s = 0; s < NSTAGES; s++) begin
        rd_q[s]  <= rd_d[s];
        rdy_q[s] <= rdy_d[s];
      end
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_interlock_unit.sv
// Directed bench for fwd_interlock_unit: vector table plus multi-cycle sequences for
// priority, clamping, reset mid-stall and counter saturation.
module tb_fwd_interlock_unit;

  localparam logic [31:0] RF0 = 32'hF000_0000;
  localparam logic [31:0] RF1 = 32'hF000_0001;
  localparam logic [31:0] S0  = 32'h0000_0022;
  localparam logic [31:0] S1  = 32'h0000_00B1;
  localparam logic [31:0] S2  = 32'h0000_0011;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  rdy;
    logic [1:0]  used;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        flush;
    logic        expStall;
    logic [1:0]  expHit;
    logic [31:0] expD0;
    logic [31:0] expD1;
    logic [15:0] expCnt;
  } vecT;

  logic        clk;
  logic        rst_n;
  logic        issueValid;
  logic        issueWe;
  logic [4:0]  issueRd;
  logic [1:0]  issueRdy;
  logic [1:0]  srcUsed;
  logic [9:0]  srcAddr;
  logic [63:0] rfData;
  logic [95:0] stageData;
  logic        flush;
  logic [63:0] srcData;
  logic [1:0]  fwdHit;
  logic        stall;
  logic [15:0] stallCnt;
  logic [63:0] satData;
  logic [1:0]  satHit;
  logic        satStall;
  logic [7:0]  satCnt;

  int total;
  int bad;
  vecT vecs[12];
  vecT v;

  fwd_interlock_unit dut (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issueValid), .issue_we_i(issueWe),
    .issue_rd_i(issueRd), .issue_rdy_i(issueRdy), .src_used_i(srcUsed),
    .src_addr_i(srcAddr), .rf_data_i(rfData), .stage_data_i(stageData),
    .flush_i(flush), .src_data_o(srcData), .fwd_hit_o(fwdHit), .stall_o(stall),
    .stall_cnt_o(stallCnt)
  );

  // Narrow counter instance so saturation is reachable in a few hundred cycles.
  fwd_interlock_unit #(.CW(8)) dutSat (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(issueValid), .issue_we_i(issueWe),
    .issue_rd_i(issueRd), .issue_rdy_i(issueRdy), .src_used_i(srcUsed),
    .src_addr_i(srcAddr), .rf_data_i(rfData), .stage_data_i(stageData),
    .flush_i(flush), .src_data_o(satData), .fwd_hit_o(satHit), .stall_o(satStall),
    .stall_cnt_o(satCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input vecT s);
    @(posedge clk);
    #1;
    issueValid = s.valid;
    issueWe    = s.we;
    issueRd    = s.rd;
    issueRdy   = s.rdy;
    srcUsed    = s.used;
    srcAddr    = {s.a1, s.a0};
    flush      = s.flush;
  endtask

  task automatic checkOutput(input vecT s, input string name);
    logic [82:0] act;
    logic [82:0] exp;
    act = {stall, fwdHit, srcData, stallCnt};
    exp = {s.expStall, s.expHit, s.expD1, s.expD0, s.expCnt};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got stall=%0b hit=%b d1=%h d0=%h cnt=%0d, want stall=%0b hit=%b d1=%h d0=%h cnt=%0d",
               name, stall, fwdHit, srcData[63:32], srcData[31:0], stallCnt,
               s.expStall, s.expHit, s.expD1, s.expD0, s.expCnt);
    end
  endtask

  task automatic step(input vecT s, input string name);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(s, name);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n      = 1'b0;
    issueValid = 1'b0;
    issueWe    = 1'b0;
    srcUsed    = 2'b00;
    flush      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rfData     = {RF1, RF0};
    stageData  = {S2, S1, S0};
    rst_n      = 1'b0;
    issueValid = 1'b0;
    issueWe    = 1'b0;
    issueRd    = 5'd0;
    issueRdy   = 2'd0;
    srcUsed    = 2'b00;
    srcAddr    = 10'd0;
    flush      = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 5'd5, 2'd0, 2'b11, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 5'd6, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0, 1'b0, 2'b01, S0,  RF1, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 5'd8, 2'd1, 2'b11, 5'd5, 5'd6, 1'b0, 1'b0, 2'b11, S1,  S0,  16'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'd9, 2'd0, 2'b10, 5'd5, 5'd8, 1'b0, 1'b1, 2'b10, RF0, S0,  16'd0};
    vecs[4]  = '{1'b1, 1'b1, 5'd9, 2'd0, 2'b10, 5'd5, 5'd8, 1'b0, 1'b0, 2'b10, RF0, S1,  16'd1};
    vecs[5]  = '{1'b1, 1'b0, 5'd0, 2'd0, 2'b11, 5'd8, 5'd6, 1'b0, 1'b0, 2'b01, S2,  RF1, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, 5'd0, 2'd0, 2'b11, 5'd0, 5'd9, 1'b0, 1'b0, 2'b10, RF0, S1,  16'd1};
    vecs[7]  = '{1'b1, 1'b1, 5'd3, 2'd2, 2'b00, 5'd9, 5'd9, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd1};
    vecs[8]  = '{1'b1, 1'b1, 5'd4, 2'd0, 2'b01, 5'd3, 5'd0, 1'b1, 1'b0, 2'b01, S0,  RF1, 16'd1};
    vecs[9]  = '{1'b1, 1'b1, 5'd7, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b1, 2'b01, S1,  RF1, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 5'd7, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 2'b01, S2,  RF1, 16'd2};
    vecs[11] = '{1'b0, 1'b0, 5'd0, 2'd0, 2'b11, 5'd7, 5'd3, 1'b0, 1'b0, 2'b01, S0,  RF1, 16'd2};

    #12;
    @(negedge clk);
    v = '{1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd0};
    checkOutput(v, "inReset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Youngest producer wins even when not ready; rdy=3 is clamped to the last stage.
    doReset();
    v = '{1'b1, 1'b1, 5'd3,  2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd0};
    applyStimulus(v);
    v.rd = 5'd10;
    applyStimulus(v);
    v.rd = 5'd3;
    applyStimulus(v);
    v = '{1'b1, 1'b1, 5'd3,  2'd3, 2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 2'b01, S0,  RF1, 16'd0};
    step(v, "prioYoungReady");
    v = '{1'b1, 1'b1, 5'd12, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b1, 2'b01, S0,  RF1, 16'd0};
    step(v, "prioNoFallbackS0");
    v = '{1'b1, 1'b1, 5'd12, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b1, 2'b01, S1,  RF1, 16'd1};
    step(v, "prioNoFallbackS1");
    v = '{1'b1, 1'b1, 5'd12, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 2'b01, S2,  RF1, 16'd2};
    step(v, "rdyClamped");

    // Asynchronous reset while a load-use stall is active.
    v = '{1'b1, 1'b1, 5'd8, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd2};
    step(v, "loadIssue");
    v = '{1'b1, 1'b1, 5'd9, 2'd0, 2'b10, 5'd0, 5'd8, 1'b0, 1'b1, 2'b10, RF0, S0,  16'd2};
    step(v, "loadUseStall");
    #1 rst_n = 1'b0;
    #1;
    v = '{1'b1, 1'b1, 5'd9, 2'd0, 2'b10, 5'd0, 5'd8, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd0};
    checkOutput(v, "rstMidStall");
    @(negedge clk);
    rst_n = 1'b1;
    step(v, "tagsDropped");

    // Same inputs held: accept, stall, stall repeats, giving 260 stalls in 390 cycles.
    doReset();
    v = '{1'b1, 1'b1, 5'd8, 2'd2, 2'b01, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, RF0, RF1, 16'd0};
    applyStimulus(v);
    repeat (390) @(posedge clk);
    #1 issueValid = 1'b0;
    @(negedge clk);
    total++;
    if (stallCnt !== 16'd260) begin
      bad++;
      $display("[TB] FAIL cntMain: got %0d want 260", stallCnt);
    end
    total++;
    if (satCnt !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL cntSaturate: got %0d want 255", satCnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
